fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Owns the architectural PC register and runs the instruction-fetch sequence.
//  Sequence: MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR.
//  Loads PC from the PC-mux output (PC_in) on LD_PC and exports PC_out to the mux.
//  Hands the fetched IR to decode with a valid/ack handshake.
//  Sits between the PC mux and the decode/control unit; owns the memory read request.
// PARAMETERS
//  RESET_PC     16'h0000  PC value after Reset
//  MEM_TIMEOUT  15        max cycles in F2 without Mem_R before fetch_err (1..255)
// PORTS
//  Clk            in   1   clock; all state changes on rising edge
//  Reset          in   1   synchronous, active-high reset
//  Run            in   1   level; fetching allowed while high
//  PC_in          in   16  next-PC value from the PC mux
//  LD_PC          in   1   load PC from PC_in this cycle
//  Data_from_mem  in   16  memory read data; valid when Mem_R=1
//  Mem_R          in   1   memory read-data ready
//  IR_ack         in   1   decode has consumed IR
//  PC_out         out  16  current PC; feeds the PC mux
//  MAR_out        out  16  memory address
//  Mem_OE         out  1   read request to memory
//  IR_out         out  16  instruction register
//  IR_valid       out  1   IR holds an unconsumed instruction
//  fetch_err      out  1   sticky memory-timeout flag
// BEHAVIOUR
//  Reset values (sync Reset wins over every other input, aborts any state):
//   PC=RESET_PC; MAR, MDR, IR = 0; IR_valid, Mem_OE, fetch_err = 0; wait count = 0; state IDLE.
//  States and transitions:
//   IDLE:
//    - Run=1 -> clear fetch_err, go F1.
//    - Run=0 -> stay.
//   F1:
//    - MAR<=PC; PC<=PC+1; go F2.
//    - 16-bit PC wraps: FFFF -> 0000.
//   F2:
//    - Mem_OE=1 (combinational from state); wait counter increments each cycle.
//    - Mem_R=1 -> MDR<=Data_from_mem, clear count, go F3.
//    - Mem_R may be high on the first F2 cycle (1-cycle memory).
//    - Count reaches MEM_TIMEOUT with Mem_R=0 -> fetch_err<=1, clear count, go IDLE; MDR unchanged.
//   F3:
//    - IR<=MDR; IR_valid<=1; go HOLD.
//   HOLD:
//    - IR_ack=1 -> IR_valid<=0; go F1 if Run=1, else IDLE.
//    - IR_ack=0 -> stay; IR and IR_valid held stable.
//  Latency:
//   - Run rising in IDLE to IR_valid high = 4 cycles with zero memory wait.
//   - Add 1 cycle per extra F2 cycle.
//  LD_PC:
//   - Honoured in every state, including during a fetch.
//   - Beats the F1 increment: if LD_PC=1 in F1, PC<=PC_in, but MAR still gets the old PC.
//   - PC_out updates the cycle after LD_PC.
//  Other rules:
//   - Run dropping during F1/F2/F3 does not abort; the fetch completes to HOLD.
//   - IR_ack while IR_valid=0 is ignored.
//   - No arithmetic other than PC+1, mod 2^16.
// TESTING
//  1. Reset, Run=1, Mem_R on first F2 cycle, data 16'h1234:
//     MAR_out=0000, PC_out=0001, IR_out=1234, IR_valid high exactly 4 cycles after Run.
//  2. Mem_R delayed 3 cycles:
//     Mem_OE high for 4 cycles, IR_valid at cycle 7, MDR captures only the Mem_R-cycle data.
//  3. LD_PC=1 with PC_in=16'h3000 during F1 from PC=16'h0040:
//     MAR=0040, PC=3000 (not 0041).
//  4. PC=16'hFFFF, fetch:
//     MAR=FFFF, PC wraps to 0000.
//  5. Mem_R held low:
//     fetch_err=1 after MEM_TIMEOUT F2 cycles, state IDLE, IR_valid=0.
//     Next Run clears fetch_err.
//  6. Reset asserted in F2 and in HOLD:
//     next cycle all outputs at reset values, PC=RESET_PC.
//  7. IR_ack withheld 5 cycles:
//     IR_out stable, IR_valid high; ack with Run=0 -> IDLE, no new MAR.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC and runs the MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR fetch sequence
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   Run                 fetching allowed while high
//   PC_in, LD_PC        next PC from the PC mux and its load strobe
//   Data_from_mem, Mem_R  memory read data and its ready flag
//   IR_ack              decode has consumed IR
//   PC_out, MAR_out     current PC and memory address
//   Mem_OE              memory read request (high throughout F2)
//   IR_out, IR_valid    fetched instruction and its valid flag
//   fetch_err           sticky memory-timeout flag, cleared by the next Run
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] PC_in,
  input  logic        LD_PC,
  input  logic [15:0] Data_from_mem,
  input  logic        Mem_R,
  input  logic        IR_ack,
  output logic [15:0] PC_out,
  output logic [15:0] MAR_out,
  output logic        Mem_OE,
  output logic [15:0] IR_out,
  output logic        IR_valid,
  output logic        fetch_err
);
  typedef enum logic [2:0] {IDLE, F1, F2, F3, HOLD} state_t;
  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);
  state_t state_q;
  logic [15:0] pc_q, pc_d, mar_q, mdr_q, ir_q;
  logic [7:0] cnt_q;
  logic irv_q, err_q;
  // an external load beats the F1 increment
  assign pc_d = LD_PC ? PC_in : (state_q == F1) ? pc_q + 16'd1 : pc_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q <= '0;
      cnt_q <= '0;
      irv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE: if (Run) begin
          err_q <= 1'b0;
          state_q <= F1;
        end
        F1: begin
          mar_q <= pc_q;
          state_q <= F2;
        end
        F2: if (Mem_R) begin
          mdr_q <= Data_from_mem;
          cnt_q <= '0;
          state_q <= F3;
        end else if (cnt_q + 8'd1 == TO) begin
          err_q <= 1'b1;
          cnt_q <= '0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        F3: begin
          ir_q <= mdr_q;
          irv_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: if (IR_ack) begin
          irv_q <= 1'b0;
          state_q <= Run ? F1 : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign PC_out = pc_q;
  assign MAR_out = mar_q;
  assign Mem_OE = state_q == F2;
  assign IR_out = ir_q;
  assign IR_valid = irv_q;
  assign fetch_err = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch transactions checked against a transaction-level model
module tb_fetch_unit;
  localparam int TO = 15;
  logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, LD_PC = 1'b0, Mem_R = 1'b0, IR_ack = 1'b0;
  logic [15:0] PC_in = '0, Data_from_mem = '0;
  logic [15:0] PC_out, MAR_out, IR_out;
  logic Mem_OE, IR_valid, fetch_err;
  int n_tests = 0, n_fail = 0;
  logic [15:0] m_pc, m_mar, m_ir;
  logic m_err;
  bit chained;
  fetch_unit #(.RESET_PC(16'h0000), .MEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .PC_in(PC_in), .LD_PC(LD_PC),
    .Data_from_mem(Data_from_mem), .Mem_R(Mem_R), .IR_ack(IR_ack),
    .PC_out(PC_out), .MAR_out(MAR_out), .Mem_OE(Mem_OE), .IR_out(IR_out),
    .IR_valid(IR_valid), .fetch_err(fetch_err)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic check_all(input string tag, input logic irv, input logic oe);
    chk({tag, ".pc"}, PC_out, m_pc);
    chk({tag, ".mar"}, MAR_out, m_mar);
    chk({tag, ".ir"}, IR_out, m_ir);
    chk({tag, ".irv"}, 16'(IR_valid), 16'(irv));
    chk({tag, ".err"}, 16'(fetch_err), 16'(m_err));
    chk({tag, ".oe"}, 16'(Mem_OE), 16'(oe));
  endtask
  task automatic do_reset(input string tag);
    Reset = 1'b1; Run = 1'b0; LD_PC = 1'b0; Mem_R = 1'b0; IR_ack = 1'b0;
    step;
    Reset = 1'b0;
    m_pc = 16'h0000; m_mar = '0; m_ir = '0; m_err = 1'b0; chained = 1'b0;
    check_all(tag, 1'b0, 1'b0);
  endtask
  task automatic load_pc(input logic [15:0] v);
    LD_PC = 1'b1; PC_in = v;
    step;
    LD_PC = 1'b0;
    m_pc = v;
    chk("ldpc", PC_out, m_pc);
  endtask
  // One fetch: delay = F2 cycles before Mem_R (>= TO means timeout)
  task automatic fetch(input int delay, input logic [15:0] data, input bit ld1, input logic [15:0] ldv,
                       input int ackwait, input bit run_after, input bit no_ack);
    logic [15:0] v;
    bit ld;
    if (!chained) begin
      Run = 1'b1;
      step;
      m_err = 1'b0;
      chk("err_clr", 16'(fetch_err), 16'(m_err));
    end
    Run = 1'($urandom_range(0, 1));
    LD_PC = ld1; PC_in = ldv;
    step;
    LD_PC = 1'b0;
    m_mar = m_pc;
    m_pc = ld1 ? ldv : m_pc + 16'd1;
    chk("f1.mar", MAR_out, m_mar);
    chk("f1.pc", PC_out, m_pc);
    for (int k = 0; k < TO; k++) begin
      chk("f2.oe", 16'(Mem_OE), 16'(1));
      Mem_R = (k == delay);
      Data_from_mem = (k == delay) ? data : 16'($urandom);
      IR_ack = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      LD_PC = ld; PC_in = v;
      step;
      Mem_R = 1'b0; LD_PC = 1'b0;
      if (ld) m_pc = v;
      chk("f2.pc", PC_out, m_pc);
      if (k == delay) break;
    end
    if (delay >= TO) begin
      Run = 1'b0; IR_ack = 1'b0;
      m_err = 1'b1; chained = 1'b0;
      check_all("timeout", 1'b0, 1'b0);
      return;
    end
    IR_ack = 1'b1;
    check_all("f3", 1'b0, 1'b0);
    step;
    IR_ack = 1'b0;
    m_ir = data;
    check_all("hold", 1'b1, 1'b0);
    for (int w = 0; w < ackwait; w++) begin
      step;
      check_all("wait", 1'b1, 1'b0);
    end
    if (no_ack) return;
    IR_ack = 1'b1; Run = run_after;
    step;
    IR_ack = 1'b0;
    chk("ack.irv", 16'(IR_valid), 16'(0));
    chk("ack.ir", IR_out, m_ir);
    if (run_after) chained = 1'b1;
    else begin
      chained = 1'b0;
      step;
      check_all("idle", 1'b0, 1'b0);
    end
  endtask
  initial begin
    do_reset("reset");
    fetch(0, 16'h1234, 1'b0, 16'h0, 0, 1'b0, 1'b0);
    fetch(3, 16'hBEEF, 1'b0, 16'h0, 0, 1'b0, 1'b0);
    load_pc(16'h0040);
    fetch(0, 16'hA5A5, 1'b1, 16'h3000, 0, 1'b0, 1'b0);
    load_pc(16'hFFFF);
    fetch(1, 16'h0F0F, 1'b0, 16'h0, 0, 1'b0, 1'b0);
    fetch(TO, 16'hDEAD, 1'b0, 16'h0, 0, 1'b0, 1'b0);
    step;
    check_all("err_idle", 1'b0, 1'b0);
    fetch(0, 16'h5555, 1'b0, 16'h0, 0, 1'b0, 1'b0);
    Run = 1'b1;
    step;
    step;
    do_reset("rst_f2");
    load_pc(16'h1200);
    fetch(2, 16'h7777, 1'b0, 16'h0, 1, 1'b0, 1'b1);
    do_reset("rst_hold");
    fetch(0, 16'hC3C3, 1'b0, 16'h0, 5, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (!chained && $urandom_range(0, 3) == 0) load_pc(16'($urandom));
      fetch(int'($urandom_range(0, TO + 1)), 16'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom),
            int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
